// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the router packet register.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DROP,
    DROP_PAR
  } state_e;

  // Widest beat the slicing helpers handle.
  localparam int unsigned HDR_MAX_W = 32;

  function automatic logic [HDR_MAX_W-1:0] field_mask(input int unsigned width);
    return (HDR_MAX_W'(1) << width) - HDR_MAX_W'(1);
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_field(input logic [HDR_MAX_W-1:0] hdr,
                                                     input int unsigned         lsb,
                                                     input int unsigned         width);
    return (hdr >> lsb) & field_mask(width);
  endfunction

  // The all-ones destination never maps to an output port.
  function automatic logic [HDR_MAX_W-1:0] invalid_addr(input int unsigned addr_w);
    return field_mask(addr_w);
  endfunction

endpackage

// File: rtl/router_skid_fifo.sv
// Small synchronous skid FIFO holding beats while the destination FIFO is full.
module router_skid_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [$clog2(SKID_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_W'(SKID_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/router_reg_p.sv
// Router packet register: header decode, forwarding with skid buffering, parity check.
// Optional payload length check enabled by ROUTER_REG_LEN_CHECK_EN.
module router_reg_p
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] dest,
  output logic              dest_valid,
  output logic              low_pkt_valid,
  output logic              parity_done,
  output logic              err,
  output logic              drop
`ifdef ROUTER_REG_LEN_CHECK_EN
  ,
  output logic              len_err
`endif
);

  localparam int unsigned SCNT_W = $clog2(SKID_DEPTH) + 1;
`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam int unsigned LEN_W  = DATA_W - ADDR_W;
  localparam int unsigned LCNT_W = LEN_W + 1;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              dest_valid_q, dest_valid_d;
  logic              low_q, low_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] par_int_q, par_int_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              len_err_q, len_err_d;
`endif

  logic              busy_c;
  logic              accept_c;
  logic              fwd_c;
  logic [ADDR_W-1:0] hdr_dest_c;
  logic              hdr_bad_c;
  logic              skid_push_c;
  logic              skid_pop_c;
  logic [DATA_W-1:0] skid_head;
  logic [SCNT_W-1:0] skid_cnt;
  logic              skid_full;
  logic              skid_empty;

  assign busy_c     = (state_q == CHECK) || (state_q == DROP_PAR) || skid_full;
  assign accept_c   = !busy_c && (((state_q == IDLE) && pkt_valid) ||
                                  (state_q == LOAD) || (state_q == DROP));
  assign hdr_dest_c = ADDR_W'(hdr_field(HDR_MAX_W'(data_in), 0, ADDR_W));
  assign hdr_bad_c  = (HDR_MAX_W'(hdr_dest_c) == invalid_addr(ADDR_W));
  assign fwd_c      = accept_c && (((state_q == IDLE) && !hdr_bad_c) || (state_q == LOAD));
  // Beats may bypass the skid only when it is empty and the FIFO can take them.
  assign skid_push_c = fwd_c && (fifo_full || !skid_empty);
  assign skid_pop_c  = !fifo_full && !skid_empty;

  router_skid_fifo #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .push_i  (skid_push_c),
    .pop_i   (skid_pop_c),
    .wdata_i (data_in),
    .rdata_o (skid_head),
    .count_o (skid_cnt),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dest_d       = dest_q;
    dest_valid_d = 1'b0;
    low_d        = low_q;
    done_d       = done_q;
    err_d        = err_q;
    drop_d       = 1'b0;
    par_int_d    = par_int_q;
    pkt_par_d    = pkt_par_q;
`ifdef ROUTER_REG_LEN_CHECK_EN
    len_d        = len_q;
    lcnt_d       = lcnt_q;
    len_err_d    = len_err_q;
`endif

    // Output stage: skid head has priority so order is preserved.
    if (!fifo_full) begin
      if (!skid_empty) begin
        dout_d       = skid_head;
        dout_valid_d = 1'b1;
      end else if (fwd_c) begin
        dout_d       = data_in;
        dout_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (hdr_bad_c) begin
            drop_d  = 1'b1;
            state_d = DROP;
          end else begin
            dest_d       = hdr_dest_c;
            dest_valid_d = 1'b1;
            par_int_d    = data_in;
            done_d       = 1'b0;
            err_d        = 1'b0;
            low_d        = 1'b0;
`ifdef ROUTER_REG_LEN_CHECK_EN
            len_d        = LEN_W'(hdr_field(HDR_MAX_W'(data_in), ADDR_W, LEN_W));
            lcnt_d       = '0;
            len_err_d    = 1'b0;
`endif
            state_d      = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          if (pkt_valid) begin
            par_int_d = par_int_q ^ data_in;
`ifdef ROUTER_REG_LEN_CHECK_EN
            lcnt_d    = lcnt_q + LCNT_W'(1);
`endif
          end else begin
            pkt_par_d = data_in;
            low_d     = 1'b1;
            state_d   = CHECK;
          end
        end
      end
      CHECK: begin
        // An empty skid means the parity beat has already been written out.
        if (skid_cnt == '0) begin
          done_d    = 1'b1;
          err_d     = (par_int_q != pkt_par_q);
`ifdef ROUTER_REG_LEN_CHECK_EN
          len_err_d = (lcnt_q != LCNT_W'(len_q));
`endif
          state_d   = IDLE;
        end
      end
      DROP: begin
        if (accept_c && !pkt_valid) state_d = DROP_PAR;
      end
      DROP_PAR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dest_q       <= '0;
      dest_valid_q <= 1'b0;
      low_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
      par_int_q    <= '0;
      pkt_par_q    <= '0;
`ifdef ROUTER_REG_LEN_CHECK_EN
      len_q        <= '0;
      lcnt_q       <= '0;
      len_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dest_q       <= dest_d;
      dest_valid_q <= dest_valid_d;
      low_q        <= low_d;
      done_q       <= done_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      par_int_q    <= par_int_d;
      pkt_par_q    <= pkt_par_d;
`ifdef ROUTER_REG_LEN_CHECK_EN
      len_q        <= len_d;
      lcnt_q       <= lcnt_d;
      len_err_q    <= len_err_d;
`endif
    end
  end

  assign busy          = busy_c;
  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign dest          = dest_q;
  assign dest_valid    = dest_valid_q;
  assign low_pkt_valid = low_q;
  assign parity_done   = done_q;
  assign err           = err_q;
  assign drop          = drop_q;
`ifdef ROUTER_REG_LEN_CHECK_EN
  assign len_err       = len_err_q;
`endif

endmodule

// File: tb/tb_router_reg_p.sv
// Directed self-checking bench for router_reg_p (DATA_W=8, ADDR_W=2, SKID_DEPTH=4).
module tb_router_reg_p;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] dest;
  logic       dest_valid;
  logic       low_pkt_valid;
  logic       parity_done;
  logic       err;
  logic       drop;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic       len_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};

  router_reg_p #(.DATA_W(8), .ADDR_W(2), .SKID_DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .busy          (busy),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dest          (dest),
    .dest_valid    (dest_valid),
    .low_pkt_valid (low_pkt_valid),
    .parity_done   (parity_done),
    .err           (err),
    .drop          (drop)
`ifdef ROUTER_REG_LEN_CHECK_EN
    ,
    .len_err       (len_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [7:0] d, input logic ff);
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_parity_done", parity_done, 0);
    chk("rst_dest", dest, 0);
    reset = 1'b0;

    // Good packet with bypass forwarding.
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, pkt[i], 1'b0);
      tick();
      chk("t1_dout", dout, pkt[i]);
      chk("t1_dout_valid", dout_valid, 1);
      if (i == 0) begin
        chk("t1_dest_valid", dest_valid, 1);
        chk("t1_dest", dest, 1);
      end
      if (i == 1) chk("t1_dest_valid_pulse", dest_valid, 0);
    end
    chk("t1_low_pkt_valid", low_pkt_valid, 1);
    chk("t1_busy_check", busy, 1);
    chk("t1_done_early", parity_done, 0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("t1_parity_done", parity_done, 1);
    chk("t1_err", err, 0);
    chk("t1_dout_valid_idle", dout_valid, 0);
    chk("t1_busy_idle", busy, 0);

    // Bad parity; flags held until the next header.
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, (i == 4) ? 8'h0E : pkt[i], 1'b0);
      tick();
      chk("t2_dout", dout, (i == 4) ? 8'h0E : pkt[i]);
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("t2_parity_done", parity_done, 1);
    chk("t2_err", err, 1);
    tick();
    tick();
    chk("t2_parity_done_held", parity_done, 1);
    chk("t2_err_held", err, 1);
    chk("t2_low_held", low_pkt_valid, 1);

    // Destination full for 6 cycles starting at the first payload beat.
    drive(1'b1, 8'h0D, 1'b0);
    tick();
    chk("t3_hdr_dout", dout, 8'h0D);
    chk("t3_done_cleared", parity_done, 0);
    chk("t3_err_cleared", err, 0);
    chk("t3_low_cleared", low_pkt_valid, 0);
    for (int i = 1; i < 5; i++) begin
      drive(i < 4, pkt[i], 1'b1);
      tick();
      chk("t3_stall_dout_valid", dout_valid, 0);
      chk("t3_stall_dout_hold", dout, 8'h0D);
      if (i == 3) chk("t3_busy_three", busy, 0);
    end
    chk("t3_busy_full", busy, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      tick();
      chk("t3_stall2_dout_valid", dout_valid, 0);
      chk("t3_stall2_busy", busy, 1);
    end
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      tick();
      chk("t3_drain_dout", dout, pkt[i]);
      chk("t3_drain_valid", dout_valid, 1);
      chk("t3_drain_done", parity_done, 0);
    end
    tick();
    chk("t3_parity_done", parity_done, 1);
    chk("t3_err", err, 0);
    chk("t3_dout_valid_end", dout_valid, 0);

    // Invalid address: packet dropped, nothing forwarded.
    drive(1'b1, 8'h0F, 1'b0);
    tick();
    chk("t4_drop", drop, 1);
    chk("t4_dout_valid0", dout_valid, 0);
    chk("t4_dest_valid", dest_valid, 0);
    drive(1'b1, 8'hAA, 1'b0);
    tick();
    chk("t4_drop_pulse", drop, 0);
    chk("t4_dout_valid1", dout_valid, 0);
    drive(1'b1, 8'hBB, 1'b0);
    tick();
    chk("t4_dout_valid2", dout_valid, 0);
    drive(1'b0, 8'hCC, 1'b0);
    tick();
    chk("t4_dout_valid3", dout_valid, 0);
    chk("t4_busy_droppar", busy, 1);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("t4_busy_idle", busy, 0);
    chk("t4_done_kept", parity_done, 1);
    chk("t4_dest_kept", dest, 1);

    // Simultaneous push and pop through the skid buffer.
    drive(1'b1, 8'h0D, 1'b1);
    tick();
    chk("t5_dv0", dout_valid, 0);
    chk("t5_dest_valid", dest_valid, 1);
    drive(1'b1, 8'h11, 1'b1);
    tick();
    chk("t5_dv1", dout_valid, 0);
    drive(1'b1, 8'h22, 1'b0);
    tick();
    chk("t5_dout0", dout, 8'h0D);
    drive(1'b1, 8'h33, 1'b0);
    tick();
    chk("t5_dout1", dout, 8'h11);
    drive(1'b0, 8'h0D, 1'b0);
    tick();
    chk("t5_dout2", dout, 8'h22);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("t5_dout3", dout, 8'h33);
    tick();
    chk("t5_dout4", dout, 8'h0D);
    chk("t5_dv4", dout_valid, 1);
    chk("t5_done_early", parity_done, 0);
    tick();
    chk("t5_parity_done", parity_done, 1);
    chk("t5_err", err, 0);

    // Asynchronous reset mid-payload, then a normal packet.
    drive(1'b1, 8'h06, 1'b0);
    tick();
    chk("t6_dest", dest, 2);
    drive(1'b1, 8'h5A, 1'b0);
    tick();
    chk("t6_dout", dout, 8'h5A);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_dout_valid", dout_valid, 0);
    chk("t6_rst_dest", dest, 0);
    chk("t6_rst_busy", busy, 0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, pkt[i], 1'b0);
      tick();
      chk("t6_dout_after", dout, pkt[i]);
      if (i == 0) chk("t6_dest_after", dest, 1);
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("t6_parity_done", parity_done, 1);
    chk("t6_err", err, 0);

`ifdef ROUTER_REG_LEN_CHECK_EN
    // Header claims 3 payload beats, only 2 arrive; parity still correct.
    drive(1'b1, 8'h0D, 1'b0);
    tick();
    drive(1'b1, 8'h11, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b0);
    tick();
    drive(1'b0, 8'h3E, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("t7_parity_done", parity_done, 1);
    chk("t7_err", err, 0);
    chk("t7_len_err", len_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_reg_p.md
Name: router_reg_p

Overview:
- Parametrised next-generation packet register for the 1x3 router datapath.
- Absorbs the header/payload/parity datapath and its control sequencing into one block; no external FSM state strobes.
- Captures the header and derives the destination, forwards every beat toward the selected destination FIFO, and buffers beats in a SKID_DEPTH-entry skid buffer while that FIFO is full.
- Accumulates XOR parity and compares it against the packet's trailing parity beat.

Parameters:
- DATA_W, 8: beat width in bits; minimum 4.
- ADDR_W, 2: destination field width, header bits [ADDR_W-1:0]. The all-ones address is invalid.
- SKID_DEPTH, 4: skid buffer entries; minimum 2, power of two.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  high for header and payload beats; the first low cycle in LOAD carries the parity beat.
- data_in  in  DATA_W  packet beat.
- fifo_full  in  1  full flag of the selected destination FIFO.
- busy  out  1  upstream must not present a beat while high.
- dout  out  DATA_W  beat toward the destination FIFO.
- dout_valid  out  1  write strobe for dout.
- dest  out  ADDR_W  destination latched from the current header.
- dest_valid  out  1  one-cycle pulse when a valid header is accepted.
- low_pkt_valid  out  1  parity beat received; cleared on the next header.
- parity_done  out  1  check complete; held until the next header.
- err  out  1  parity mismatch; qualified by parity_done.
- drop  out  1  one-cycle pulse when a packet with an invalid address is discarded.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Skid buffer is emptied and parity registers are cleared.
  - Any partial packet is discarded.
- Header format: [ADDR_W-1:0] is the destination, [DATA_W-1:ADDR_W] is the payload length (unsigned).
- A beat is accepted when busy=0 and the upstream drives it. In IDLE a beat exists only when pkt_valid=1.
- busy = (state==CHECK) || (state==DROP_PAR) || (skid count==SKID_DEPTH). It is combinational from registered state.
- FSM states:
  - IDLE: a header is accepted when pkt_valid=1.
    - Valid address: latch header and dest, pulse dest_valid, set internal parity to the header value, clear parity_done, err and low_pkt_valid, forward the header beat, go to LOAD.
    - Invalid address (all ones): pulse drop, go to DROP.
  - LOAD:
    - pkt_valid=1: payload beat; forward it and XOR it into internal parity.
    - pkt_valid=0: parity beat; forward it, latch it as packet parity, set low_pkt_valid, go to CHECK.
  - CHECK: wait until the skid buffer is empty and the final beat has been written. Then, in one cycle, set parity_done=1 and err=(internal!=packet parity), and go to IDLE.
  - DROP: consume beats with no output while pkt_valid=1. The first pkt_valid=0 cycle consumes the parity beat and goes to DROP_PAR.
  - DROP_PAR: one cycle, then IDLE.
- Forwarding:
  - A registered output stage is fed from the skid buffer head, or, when the buffer is empty, directly from the accepted beat (bypass).
  - dout and dout_valid update one cycle after selection, and only when fifo_full=0.
  - Latency is 1 cycle with fifo_full low.
  - When fifo_full=1, accepted beats enter the skid buffer, dout_valid=0, and dout holds its last value.
  - Order is preserved; no beat is lost or duplicated.
- Boundary cases:
  - Zero-length payload: the header is immediately followed by a pkt_valid=0 parity beat.
  - Skid full and fifo_full deasserting in the same cycle: the pop happens first and busy drops the next cycle.
  - Simultaneous push and pop: count is unchanged and pointers wrap modulo SKID_DEPTH.

Optional Feature:
- Macro ROUTER_REG_LEN_CHECK_EN.
- Defined:
  - Adds an output port len_err (1 bit), reset 0.
  - A payload beat counter of width DATA_W-ADDR_W+1 resets on each accepted header.
  - At the CHECK completion cycle, len_err = (count != header length). It is held and cleared with parity_done.
- Undefined: no port, no counter; the header length field is ignored.

Decomposition:
- Package router_pkg:
  - FSM state enum: IDLE, LOAD, CHECK, DROP, DROP_PAR.
  - Header field slicing helper functions.
  - Invalid-address constant.
- One natural sub-module, router_skid_fifo: synchronous FIFO with count and full/empty flags, parametrised by DATA_W and SKID_DEPTH, using the same asynchronous active-high reset.

Test Plan:
- Good packet, DATA_W=8, ADDR_W=2: header 0x0D (dest 1, length 3), payload 0x11,0x22,0x33, parity 0x0D, fifo_full=0.
  -> dest_valid pulse with dest=1; five dout beats 0x0D,0x11,0x22,0x33,0x0D on consecutive cycles at 1-cycle latency; parity_done=1, err=0.
- Same packet with parity beat 0x0E -> parity_done=1, err=1; both held until the next header clears them.
- fifo_full=1 for 6 cycles starting at the first payload beat.
  -> busy=1 once 4 beats are buffered.
  -> After release, dout sequence is still 0x0D,0x11,0x22,0x33,0x0D with no gaps in content.
  -> parity_done asserts only after the last beat is written.
- Header 0x0F (address 2'b11) with 2 payload beats plus parity -> drop pulse, dout_valid stays 0, FSM returns to IDLE.
- reset asserted asynchronously mid-payload -> all outputs 0 before the next clock edge; the next header is processed normally.
- With ROUTER_REG_LEN_CHECK_EN: header 0x0D followed by only 2 payload beats and correct parity -> err=0, len_err=1.
